// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared width constant and count type for the countdown timer
package countdown_pkg;

  localparam int COUNT_W = 8;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/countdown_8bit_if.sv
// rtl/countdown_8bit_if.sv - control/status bundle between a timer client (master) and the timer (slave)
interface countdown_8bit_if
  import countdown_pkg::*;
#(
  parameter int WIDTH = COUNT_W
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             auto;
  logic             out_en;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             running;

  modport master (
    output en, load, data_in, auto, out_en,
    input  data_out, tc, running
  );

  modport slave (
    input  en, load, data_in, auto, out_en,
    output data_out, tc, running
  );

endinterface

// File: rtl/countdown_8bit.sv
// rtl/countdown_8bit.sv - loadable down-counter with one-cycle terminal-count pulse
// COUNTDOWN_AUTORELOAD_EN adds the reload register; without it every run is one-shot.
module countdown_8bit
  import countdown_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic              clk,
  input  logic              rst,
  countdown_8bit_if.slave   bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_running;
  logic             r_tc;
  logic             w_auto;
  logic             w_terminal;

  assign w_terminal = (r_count == WIDTH'(1));

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] r_reload;

  assign w_auto = bus.auto;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reload <= '0;
    end else if (bus.load) begin
      r_reload <= bus.data_in;
    end
  end
`else
  // Folding auto to zero keeps the port wired while the select has no effect.
  assign w_auto = bus.auto & 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_running <= 1'b0;
      r_tc      <= 1'b0;
    end else if (bus.load) begin
      r_count   <= bus.data_in;
      r_running <= (bus.data_in != '0);
      r_tc      <= 1'b0;
    end else if (bus.en && r_running) begin
      if (w_terminal) begin
        r_tc <= 1'b1;
        if (w_auto) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          r_count <= r_reload;
`else
          r_count <= '0;
`endif
        end else begin
          r_count   <= '0;
          r_running <= 1'b0;
        end
      end else begin
        r_count <= r_count - WIDTH'(1);
        r_tc    <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign bus.data_out = bus.out_en ? r_count : '0;
  assign bus.tc       = r_tc;
  assign bus.running  = r_running;

endmodule

// File: tb/tb_countdown_8bit.sv
// tb/tb_countdown_8bit.sv - directed vector bench for countdown_8bit
module tb_countdown_8bit;

  logic clk;
  logic rst;

  countdown_8bit_if #(.WIDTH(8)) bus ();

  countdown_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       auto_sel;
    logic       out_en;
    logic [7:0] din;
    logic [7:0] exp_do;
    logic       exp_tc;
    logic       exp_run;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic ld, input logic e, input logic a,
                              input logic oe, input logic [7:0] d, input logic [7:0] edo,
                              input logic etc, input logic erun);
    vec_t v;
    v.rst = r; v.load = ld; v.en = e; v.auto_sel = a; v.out_en = oe; v.din = d;
    v.exp_do = edo; v.exp_tc = etc; v.exp_run = erun;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [7:0] edo, input logic etc,
                           input logic erun);
    checks++;
    if (bus.data_out !== edo) begin
      errors++;
      $display("FAIL %s data_out got %02h want %02h", name, bus.data_out, edo);
    end
    checks++;
    if (bus.tc !== etc) begin
      errors++;
      $display("FAIL %s tc got %b want %b", name, bus.tc, etc);
    end
    checks++;
    if (bus.running !== erun) begin
      errors++;
      $display("FAIL %s running got %b want %b", name, bus.running, erun);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic e, input logic a,
                       input logic oe, input logic [7:0] d);
    @(negedge clk);
    rst = r; bus.load = ld; bus.en = e; bus.auto = a; bus.out_en = oe; bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [7:0] e_do;
    logic e_tc, e_run;

    rst = 1'b1; bus.load = 1'b0; bus.en = 1'b0; bus.auto = 1'b0;
    bus.out_en = 1'b1; bus.data_in = 8'h00;

    // reset overrides load/en
    vecs.push_back(mk(1, 1, 1, 0, 1, 8'h55, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 8'h55, 8'h00, 0, 0));
    // one-shot of 5
    vecs.push_back(mk(0, 1, 1, 0, 1, 8'h05, 8'h05, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h04, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h03, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h02, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h01, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0));
    // load of zero stays idle
    vecs.push_back(mk(0, 1, 1, 0, 1, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0));
    // stalls: en 1,0,0,1,1,1
    vecs.push_back(mk(0, 1, 0, 0, 1, 8'h04, 8'h04, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h03, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h03, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h03, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h02, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h01, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 0));
    // load collides with terminal count
    vecs.push_back(mk(0, 1, 0, 0, 1, 8'h02, 8'h02, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h01, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 8'h0A, 8'h0A, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h09, 0, 1));
    // out_en low masks data_out while counting continues
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h07, 0, 1));
    // reset mid-count
    vecs.push_back(mk(1, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].auto_sel, vecs[i].out_en, vecs[i].din);
      check_out($sformatf("vec%0d", i), vecs[i].exp_do, vecs[i].exp_tc, vecs[i].exp_run);
    end

    // auto-reload with N=3 over 12 enabled cycles
    drive(0, 1, 0, 1, 1, 8'h03);
    check_out("auto3_load", 8'h03, 0, 1);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 1, 1, 1, 8'h00);
`ifdef COUNTDOWN_AUTORELOAD_EN
      e_do  = 8'(3 - (k % 3));
      e_tc  = ((k % 3) == 0);
      e_run = 1'b1;
`else
      e_do  = (k < 3) ? 8'(3 - k) : 8'h00;
      e_tc  = (k == 3);
      e_run = (k < 3);
`endif
      if (bus.tc === 1'b1) pulses++;
      check_out($sformatf("auto3_c%0d", k), e_do, e_tc, e_run);
    end
    checks++;
`ifdef COUNTDOWN_AUTORELOAD_EN
    if (pulses != 4) begin
      errors++;
      $display("FAIL auto3_pulses got %0d want 4", pulses);
    end
`else
    if (pulses != 1) begin
      errors++;
      $display("FAIL auto3_pulses got %0d want 1", pulses);
    end
`endif

    // auto-reload with N=1 pulses every enabled cycle
    drive(0, 1, 0, 1, 1, 8'h01);
    check_out("auto1_load", 8'h01, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, 1, 1, 8'h00);
`ifdef COUNTDOWN_AUTORELOAD_EN
      check_out($sformatf("auto1_c%0d", k), 8'h01, 1, 1);
`else
      check_out($sformatf("auto1_c%0d", k), 8'h00, (k == 1), 0);
`endif
    end

    // a stall in auto mode never produces tc
    drive(0, 0, 0, 1, 1, 8'h00);
`ifdef COUNTDOWN_AUTORELOAD_EN
    check_out("auto1_stall", 8'h01, 0, 1);
`else
    check_out("auto1_stall", 8'h00, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
